// File: rtl/f36m_mult_if.sv
// Operand/result bus of the GF(3^6M) multiply unit: start/ready/done handshake
// plus the two operands, the mode select and the result register.
interface f36m_mult_if #(
  parameter int M = 3
);
  localparam int W = 12 * M;

  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic [W-1:0] c;
  logic         done;

  modport master (output start, mode, a, b, input ready, c, done);
  modport slave  (input start, mode, a, b, output ready, c, done);
endinterface

// File: rtl/f36m_mult_p.sv
// GF(3^6M) multiplier: six-product Karatsuba over GF(3^2M), NMUL parallel
// digit-serial GF(3^2M) multipliers time-shared across 6/NMUL rounds.

// GF(3^2M) = GF(3^M)[i]/(i^2+1), GF(3^M) = GF(3)[x]/(x^M-x-1); trits coded 00/01/10.
// Three MSB-first digit-serial GF(3^M) products; done is a level after M digits.
module f32m_mult #(
  parameter int M = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [4*M-1:0] a,
  input  logic [4*M-1:0] b,
  output logic [4*M-1:0] c,
  output logic           done
);
  localparam int FW = 2 * M;
  localparam int CW = $clog2(M + 1);

  function automatic logic [1:0] trit_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [1:0] trit_mul(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd0 || y == 2'd0) return 2'd0;
    return (x == y) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [FW-1:0] fq_add(input logic [FW-1:0] x, input logic [FW-1:0] y);
    logic [FW-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = trit_add(x[2*i +: 2], y[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [FW-1:0] fq_neg(input logic [FW-1:0] x);
    logic [FW-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = {x[2*i], x[2*i+1]};
    return r;
  endfunction

  // acc*x + d*y, folding the trit shifted out through x^M = x + 1
  function automatic logic [FW-1:0] fq_step(input logic [FW-1:0] acc, input logic [FW-1:0] y,
                                            input logic [1:0] d);
    logic [FW-1:0] r;
    logic [1:0]    top;
    top    = acc[FW-1 -: 2];
    r      = {acc[FW-3:0], top};
    r[3:2] = trit_add(r[3:2], top);
    for (int i = 0; i < M; i++) r[2*i +: 2] = trit_add(r[2*i +: 2], trit_mul(y[2*i +: 2], d));
    return r;
  endfunction

  logic [FW-1:0] ma [3];
  logic [FW-1:0] mb [3];
  logic [FW-1:0] acc [3];
  logic [1:0]    dig [3];
  logic [CW-1:0] cnt;

  always_comb begin
    int sh;
    ma[0] = a[FW-1:0];
    mb[0] = b[FW-1:0];
    ma[1] = a[2*FW-1:FW];
    mb[1] = b[2*FW-1:FW];
    ma[2] = fq_add(a[FW-1:0], a[2*FW-1:FW]);
    mb[2] = fq_add(b[FW-1:0], b[2*FW-1:FW]);
    sh = (cnt < CW'(M)) ? 2 * (M - 1 - int'(cnt)) : 0;
    for (int k = 0; k < 3; k++) dig[k] = 2'(mb[k] >> sh);
  end

  assign done = (cnt == CW'(M));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      for (int k = 0; k < 3; k++) acc[k] <= '0;
    end else if (!done) begin
      cnt <= cnt + CW'(1);
      for (int k = 0; k < 3; k++) acc[k] <= fq_step(acc[k], ma[k], dig[k]);
    end
  end

  assign c[FW-1:0]    = fq_add(acc[0], fq_neg(acc[1]));
  assign c[2*FW-1:FW] = fq_add(acc[2], fq_neg(fq_add(acc[0], acc[1])));
endmodule

module f36m_mult_p #(
  parameter int M    = 3,
  parameter int NMUL = 1
) (
  input logic        clk,
  input logic        reset,
  f36m_mult_if.slave bus
);
  localparam int R  = 6 / NMUL;
  localparam int LW = 4 * M;
  localparam int TW = 2 * M;

  if (!(NMUL == 1 || NMUL == 2 || NMUL == 3 || NMUL == 6)) begin : g_bad_nmul
    $error("f36m_mult_p: NMUL must be 1, 2, 3 or 6");
  end

  function automatic logic [1:0] trit_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  function automatic logic [LW-1:0] f32m_add(input logic [LW-1:0] x, input logic [LW-1:0] y);
    logic [LW-1:0] r;
    for (int i = 0; i < TW; i++) r[2*i +: 2] = trit_add(x[2*i +: 2], y[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [LW-1:0] f32m_neg(input logic [LW-1:0] x);
    logic [LW-1:0] r;
    for (int i = 0; i < TW; i++) r[2*i +: 2] = {x[2*i], x[2*i+1]};
    return r;
  endfunction

  function automatic logic [LW-1:0] f32m_add3(input logic [LW-1:0] x, input logic [LW-1:0] y,
                                              input logic [LW-1:0] z);
    return f32m_add(f32m_add(x, y), z);
  endfunction

  function automatic logic [LW-1:0] f32m_add4(input logic [LW-1:0] w, input logic [LW-1:0] x,
                                              input logic [LW-1:0] y, input logic [LW-1:0] z);
    return f32m_add(f32m_add(w, x), f32m_add(y, z));
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RST, S_WAIT, S_COMB} state_t;
  state_t state_q, state_d;

  logic [LW-1:0]   a_q [3];
  logic [LW-1:0]   b_q [3];
  logic [LW-1:0]   x_q [6];
  logic [LW-1:0]   op_a [6];
  logic [LW-1:0]   op_b [6];
  logic [LW-1:0]   mul_a [NMUL];
  logic [LW-1:0]   mul_b [NMUL];
  logic [LW-1:0]   mul_c [NMUL];
  logic [2:0]      slot [NMUL];
  logic [NMUL-1:0] mul_done;
  logic [2:0]      r_q;
  logic            mac_q, accept, all_done, sub_rst, last_round, done_q;
  logic [LW-1:0]   d1, d2, d3, p0, p1, p2;
  logic [3*LW-1:0] c_q;

  assign accept     = (state_q == S_IDLE) && bus.start && !reset;
  assign all_done   = &mul_done;
  assign last_round = (r_q == 3'(R - 1));
  assign sub_rst    = reset || (state_q != S_WAIT);

  always_comb begin
    op_a[0] = a_q[2];                     op_b[0] = b_q[2];
    op_a[1] = f32m_add(a_q[2], a_q[1]);   op_b[1] = f32m_add(b_q[2], b_q[1]);
    op_a[2] = a_q[1];                     op_b[2] = b_q[1];
    op_a[3] = f32m_add(a_q[2], a_q[0]);   op_b[3] = f32m_add(b_q[2], b_q[0]);
    op_a[4] = f32m_add(a_q[1], a_q[0]);   op_b[4] = f32m_add(b_q[1], b_q[0]);
    op_a[5] = a_q[0];                     op_b[5] = b_q[0];
    for (int j = 0; j < NMUL; j++) begin
      slot[j]  = r_q * 3'(NMUL) + 3'(j);
      mul_a[j] = op_a[slot[j]];
      mul_b[j] = op_b[slot[j]];
    end
  end

  for (genvar j = 0; j < NMUL; j++) begin : g_mul
    f32m_mult #(.M(M)) u_mul (
      .clk   (clk),
      .reset (sub_rst),
      .a     (mul_a[j]),
      .b     (mul_b[j]),
      .c     (mul_c[j]),
      .done  (mul_done[j])
    );
  end

  always_comb begin
    d3 = f32m_add3(x_q[1], f32m_neg(x_q[0]), f32m_neg(x_q[2]));
    d1 = f32m_add3(x_q[4], f32m_neg(x_q[2]), f32m_neg(x_q[5]));
    d2 = f32m_add4(x_q[3], x_q[2], f32m_neg(x_q[0]), f32m_neg(x_q[5]));
    p0 = f32m_add(x_q[5], d3);
    p1 = f32m_add3(d1, d3, x_q[0]);
    p2 = f32m_add(d2, x_q[0]);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RST;
      S_RST:   state_d = S_WAIT;
      S_WAIT:  if (all_done) state_d = last_round ? S_COMB : S_RST;
      S_COMB:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) r_q <= '0;
      else if (state_q == S_WAIT && all_done && !last_round) r_q <= r_q + 3'd1;
    end
  end

  // Operand latches and product slots carry no reset: every slot is rewritten before COMB.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        a_q[i] <= bus.a[i*LW +: LW];
        b_q[i] <= (bus.mode == 2'b01) ? bus.a[i*LW +: LW] : bus.b[i*LW +: LW];
      end
      mac_q <= (bus.mode == 2'b10);
    end
    if (state_q == S_WAIT && all_done)
      for (int j = 0; j < NMUL; j++) x_q[slot[j]] <= mul_c[j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_COMB);
      if (state_q == S_COMB)
        c_q <= mac_q ? {f32m_add(p2, c_q[2*LW +: LW]), f32m_add(p1, c_q[LW +: LW]),
                        f32m_add(p0, c_q[0 +: LW])}
                     : {p2, p1, p0};
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = done_q;
  assign bus.c     = c_q;
endmodule

// File: tb/tb_f36m_mult_p.sv
// Bench for f36m_mult_p: one instance per legal NMUL, table vectors, random
// products against a schoolbook polynomial model, MAC, handshake and reset cases.
module tb_f36m_mult_p;
  localparam int M  = 3;
  localparam int FW = 2 * M;
  localparam int LW = 4 * M;
  localparam int W  = 12 * M;
  localparam int L  = M + 1;

  logic         clk;
  logic         reset_v [4];
  logic         start_v [4];
  logic [1:0]   mode_v  [4];
  logic [W-1:0] a_v     [4];
  logic [W-1:0] b_v     [4];
  logic         ready_v [4];
  logic         done_v  [4];
  logic [W-1:0] c_v     [4];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NMG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
    f36m_mult_if #(.M(M)) bus ();
    assign bus.start  = start_v[g];
    assign bus.mode   = mode_v[g];
    assign bus.a      = a_v[g];
    assign bus.b      = b_v[g];
    assign ready_v[g] = bus.ready;
    assign done_v[g]  = bus.done;
    assign c_v[g]     = bus.c;
    f36m_mult_p #(.M(M), .NMUL(NMG)) u_dut (
      .clk   (clk),
      .reset (reset_v[g]),
      .bus   (bus)
    );
  end

  // ---------------- reference model: plain polynomial arithmetic ----------------
  function automatic int tget(input logic [FW-1:0] x, input int i);
    return int'(x[2*i +: 2]);
  endfunction

  function automatic logic [FW-1:0] fq_add(input logic [FW-1:0] x, input logic [FW-1:0] y);
    logic [FW-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((tget(x, i) + tget(y, i)) % 3);
    return r;
  endfunction

  function automatic logic [FW-1:0] fq_sub(input logic [FW-1:0] x, input logic [FW-1:0] y);
    logic [FW-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((tget(x, i) + 3 - tget(y, i)) % 3);
    return r;
  endfunction

  function automatic logic [FW-1:0] fq_mul(input logic [FW-1:0] x, input logic [FW-1:0] y);
    int p [2*M];
    logic [FW-1:0] r;
    for (int k = 0; k < 2 * M; k++) p[k] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) p[i+j] += tget(x, i) * tget(y, j);
    for (int k = 2 * M - 2; k >= M; k--) begin
      p[k-M]   += p[k];
      p[k-M+1] += p[k];
      p[k]      = 0;
    end
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(p[i] % 3);
    return r;
  endfunction

  function automatic logic [LW-1:0] fq2_add(input logic [LW-1:0] u, input logic [LW-1:0] v);
    return {fq_add(u[LW-1:FW], v[LW-1:FW]), fq_add(u[FW-1:0], v[FW-1:0])};
  endfunction

  function automatic logic [LW-1:0] fq2_mul(input logic [LW-1:0] u, input logic [LW-1:0] v);
    logic [FW-1:0] lo, hi;
    lo = fq_sub(fq_mul(u[FW-1:0], v[FW-1:0]), fq_mul(u[LW-1:FW], v[LW-1:FW]));
    hi = fq_add(fq_mul(u[FW-1:0], v[LW-1:FW]), fq_mul(u[LW-1:FW], v[FW-1:0]));
    return {hi, lo};
  endfunction

  function automatic logic [W-1:0] f6_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    for (int i = 0; i < 3; i++) r[i*LW +: LW] = fq2_add(x[i*LW +: LW], y[i*LW +: LW]);
    return r;
  endfunction

  // schoolbook product in rho, then rho^3 = rho + 1
  function automatic logic [W-1:0] f6_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [LW-1:0] cc [5];
    for (int k = 0; k < 5; k++) cc[k] = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        cc[i+j] = fq2_add(cc[i+j], fq2_mul(x[i*LW +: LW], y[j*LW +: LW]));
    return {fq2_add(cc[2], cc[4]), fq2_add(fq2_add(cc[1], cc[3]), cc[4]), fq2_add(cc[0], cc[3])};
  endfunction

  function automatic logic [W-1:0] rand_elem();
    logic [W-1:0] r;
    for (int t = 0; t < W / 2; t++) r[2*t +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  function automatic int nmul_of(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 2 : (idx == 2) ? 3 : 6;
  endfunction

  function automatic int exp_lat(input int idx);
    return (6 / nmul_of(idx)) * (L + 1) + 1;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic pulse_reset(input int idx);
    reset_v[idx] = 1'b1;
    tick();
    reset_v[idx] = 1'b0;
  endtask

  task automatic run_op(input int idx, input logic [1:0] md, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit scramble, output logic [W-1:0] cres,
                        output int lat, output int ndone, output logic rdy1);
    int bound = 0;
    while (!ready_v[idx] && bound < 200) begin
      tick();
      bound++;
    end
    start_v[idx] = 1'b1;
    mode_v[idx]  = md;
    a_v[idx]     = a;
    b_v[idx]     = b;
    tick();
    start_v[idx] = 1'b0;
    lat = -1; ndone = 0; cres = '0; rdy1 = 1'bx;
    for (int cyc = 1; cyc <= 100 && (lat < 0 || cyc <= lat + 4); cyc++) begin
      if (scramble) begin
        a_v[idx]    = rand_elem();
        b_v[idx]    = rand_elem();
        mode_v[idx] = 2'($urandom_range(0, 3));
      end
      tick();
      if (cyc == 1) rdy1 = ready_v[idx];
      if (done_v[idx]) begin
        ndone++;
        if (lat < 0) begin
          lat  = cyc;
          cres = c_v[idx];
        end
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int           idx;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  initial begin
    vec_t         tbl [8];
    logic [W-1:0] one, x, y, z, cres, prev;
    int           lat, nd, acc, dn;
    logic         rdy1, pend;

    one = W'(1);
    x   = rand_elem(); x[1:0] = 2'b01;
    y   = rand_elem(); y[1:0] = 2'b10;
    z   = rand_elem();

    for (int i = 0; i < 4; i++) begin
      reset_v[i] = 1'b1; start_v[i] = 1'b0; mode_v[i] = 2'b00;
      a_v[i] = '0; b_v[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 4; i++) reset_v[i] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_ready_n%0d", nmul_of(i)), W'(ready_v[i]), W'(1));
      check($sformatf("reset_done_n%0d", nmul_of(i)), W'(done_v[i]), W'(0));
      check($sformatf("reset_c_n%0d", nmul_of(i)), c_v[i], '0);
    end

    tbl[0] = '{3, 2'b00, one, x, x};
    tbl[1] = '{0, 2'b00, x, one, x};
    tbl[2] = '{1, 2'b11, one, y, y};
    tbl[3] = '{2, 2'b01, x, {$urandom, $urandom}, f6_mul(x, x)};
    tbl[4] = '{3, 2'b01, y, {$urandom, $urandom}, f6_mul(y, y)};
    tbl[5] = '{0, 2'b00, '0, z, '0};
    tbl[6] = '{2, 2'b00, x, y, f6_mul(x, y)};
    tbl[7] = '{1, 2'b00, z, x, f6_mul(z, x)};
    for (int t = 0; t < 8; t++) begin
      run_op(tbl[t].idx, tbl[t].mode, tbl[t].a, tbl[t].b, 1'b0, cres, lat, nd, rdy1);
      check($sformatf("tbl%0d_c", t), cres, tbl[t].exp);
      check($sformatf("tbl%0d_latency", t), W'(lat), W'(exp_lat(tbl[t].idx)));
      check($sformatf("tbl%0d_done_pulses", t), W'(nd), W'(1));
      check($sformatf("tbl%0d_ready_low", t), W'(rdy1), W'(0));
    end

    for (int i = 0; i < 4; i++)
      for (int n = 0; n < 200; n++) begin
        logic [W-1:0] ra, rb;
        ra = rand_elem();
        rb = rand_elem();
        run_op(i, 2'b00, ra, rb, (n % 4) == 0, cres, lat, nd, rdy1);
        check($sformatf("rand_n%0d_c", nmul_of(i)), cres, f6_mul(ra, rb));
        check($sformatf("rand_n%0d_latency", nmul_of(i)), W'(lat), W'(exp_lat(i)));
      end

    pulse_reset(0);
    run_op(0, 2'b10, one, x, 1'b0, cres, lat, nd, rdy1);
    check("mac_1x", cres, x);
    run_op(0, 2'b10, one, x, 1'b0, cres, lat, nd, rdy1);
    check("mac_2x", cres, f6_add(x, x));
    run_op(0, 2'b10, one, x, 1'b0, cres, lat, nd, rdy1);
    check("mac_3x_zero", cres, '0);
    run_op(0, 2'b00, y, z, 1'b0, prev, lat, nd, rdy1);
    run_op(0, 2'b10, x, y, 1'b0, cres, lat, nd, rdy1);
    check("mac_after_mul", cres, f6_add(f6_mul(y, z), f6_mul(x, y)));

    pulse_reset(2);
    start_v[2] = 1'b1; mode_v[2] = 2'b10; a_v[2] = one; b_v[2] = x;
    acc = 0; dn = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc == 60) start_v[2] = 1'b0;
      pend = ready_v[2] && start_v[2];
      tick();
      if (pend) acc++;
      if (done_v[2]) begin
        dn++;
        check("hold_mac_c", c_v[2], (dn % 3 == 0) ? '0 : (dn % 3 == 1) ? x : f6_add(x, x));
      end
    end
    check("hold_accept_per_done", W'(acc), W'(dn));
    check("hold_accepts_min", W'(acc >= 4), W'(1));

    run_op(1, 2'b00, x, y, 1'b0, cres, lat, nd, rdy1);
    start_v[1] = 1'b1; mode_v[1] = 2'b00; a_v[1] = z; b_v[1] = y;
    tick();
    start_v[1] = 1'b0;
    repeat (L + 2) tick();
    reset_v[1] = 1'b1;
    tick();
    reset_v[1] = 1'b0;
    check("midreset_ready", W'(ready_v[1]), W'(1));
    check("midreset_c", c_v[1], '0);
    check("midreset_done", W'(done_v[1]), W'(0));
    nd = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      tick();
      if (done_v[1]) nd++;
    end
    check("midreset_no_done", W'(nd), W'(0));
    run_op(1, 2'b00, z, y, 1'b0, cres, lat, nd, rdy1);
    check("midreset_fresh_c", cres, f6_mul(z, y));
    check("midreset_fresh_latency", W'(lat), W'(exp_lat(1)));

    reset_v[0] = 1'b1; start_v[0] = 1'b1; mode_v[0] = 2'b00; a_v[0] = x; b_v[0] = y;
    tick();
    reset_v[0] = 1'b0; start_v[0] = 1'b0;
    check("reset_beats_start_ready", W'(ready_v[0]), W'(1));
    tick();
    check("reset_beats_start_ready2", W'(ready_v[0]), W'(1));
    nd = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      tick();
      if (done_v[0]) nd++;
    end
    check("reset_beats_start_no_done", W'(nd), W'(0));
    check("reset_beats_start_c", c_v[0], '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/f36m_mult_p.md
# f36m_mult_p

Parametrised GF(3^{6M}) multiply unit. Computes a*b with the six-product Karatsuba schedule over GF(3^{2M}). The number of parallel `f32m_mult` instances (NMUL) trades area against latency. Adds a start/ready/done handshake, a squaring mode and a multiply-accumulate mode. Sits beside the existing Tate-pairing datapath blocks and is a drop-in for any GF(3^{6M}) product that needs throughput control.

## Interface
- NMUL, 1: number of `f32m_mult` instances. Legal values are 1, 2, 3 and 6. Other values are an elaboration error.
- R (localparam), 6/NMUL: number of scheduling rounds.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request. Accepted only when ready=1.
- mode  in  2  00 MUL: c=a*b. 01 SQR: c=a*a, b ignored. 10 MAC: c=a*b+c_prev. 11 is treated as MUL.
- a, b  in  `W6+1` each  operands {x2,x1,x0} in GF(3^{2M}) limbs, `W2+1` bits each
- ready  out  1  high in IDLE
- c  out  `W6+1`  result register. Holds its value until the next completion.
- done  out  1  one-cycle pulse when c is updated

## Operation
- States: IDLE, RST, WAIT, COMB.
- IDLE: ready=1. When start=1, latch a into A. Latch b into B, or a into B in SQR mode. Latch mode. Set round index r=0. Go to RST.
- RST: hold all sub-multiplier resets high for one cycle. Drive the mux inputs for products r*NMUL..r*NMUL+NMUL-1. Go to WAIT.
- WAIT: release the resets and keep the mux inputs stable. Sub-multiplier `done` is a level held until that multiplier is reset. Once every active instance reports done:
  - On that edge, write each product into its slot x[k].
  - If r<R-1, set r=r+1 and go to RST.
  - Otherwise go to COMB.
- Product slots, with operand limbs A={a2,a1,a0} and B={b2,b1,b0}:
  - x0=a2*b2
  - x1=(a2+a1)(b2+b1)
  - x2=a1*b1
  - x3=(a2+a0)(b2+b0)
  - x4=(a1+a0)(b1+b0)
  - x5=a0*b0
- Instance j in round r computes slot r*NMUL+j.
- COMB computes the combination combinationally from x0..x5:
  - d3=x1-x0-x2
  - d1=x4-x2-x5
  - d2=x3+x2-x0-x5
  - p0=x5+d3, p1=d1+d3+x0, p2=d2+x0
- COMB register update:
  - MUL/SQR: c <= {p2,p1,p0}.
  - MAC: c <= {p2,p1,p0} + c, using limb-wise `f32m_add`.
  - Pulse done=1 and go to IDLE.
- All arithmetic is in GF(3^{2M}) using the existing `f32m_add`, `f32m_neg`, `f32m_add3`, `f32m_add4` and `f32m_mult`. No carries and no width growth.
- start while ready=0 is ignored. No queueing.
- a, b and mode may change freely after acceptance. Only the latched copies are used.
- Reset:
  - Forces IDLE from any state, including mid-round.
  - Holds all sub-multipliers in reset.
  - Clears c to 0 (MAC accumulator cleared) and done to 0.
  - Discards partial products.
- Reset values: ready=1, done=0, c=0.

## Timing
- L = cycles from a sub-multiplier's reset release to its done (fixed by `f32m_mult`).
- Start accepted at edge 0. Each round takes 1+L cycles. COMB takes 1 cycle. done is high in cycle R*(L+1)+1, and c is valid from the same cycle.
- ready goes low the cycle after acceptance. It returns high the same cycle done pulses, so back-to-back start is accepted on the done cycle.
- MAC uses the c value present at COMB, i.e. the previous result, including one completing in the immediately preceding operation.
- A reset asserted in the same cycle as start wins. Nothing is latched.

## Test plan
- NMUL=6, MUL: a=1 (a0=1, a1=a2=0), b=random X -> c=X. done pulses once, at cycle L+2 after acceptance.
- NMUL=1,2,3,6, MUL, 200 random (a,b) each -> c equals the reference-model product. Latency equals R*(L+1)+1 exactly.
- SQR: a=X, b=garbage -> c equals the MUL result of (X,X).
- MAC sequence after reset:
  - MAC(1,X) -> c=X.
  - MAC(1,X) -> c=2X.
  - MAC(1,X) -> c=0, since 3X=0 in characteristic 3.
- Handshake: start held high continuously -> exactly one acceptance per done. Inputs changed mid-operation do not affect c.
- Reset asserted in WAIT of round 1 (NMUL=2) -> next cycle ready=1, c=0, done=0. A fresh MUL then gives the correct result with full latency.
